// File: rtl/rv_p4_pkg.sv
// Shared RX-path types: framer per-port state, cell geometry and the framed-cell payload.
package rv_p4_pkg;

  localparam int unsigned CELL_BYTES  = 64;
  localparam int unsigned RX_PORT_W   = 5;
  localparam int unsigned EOP_LEN_W   = 7;
  localparam int unsigned PKT_LEN_W   = 14;
  localparam int unsigned CELL_DATA_W = CELL_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    DISCARD = 2'd2
  } framer_state_e;

  typedef struct packed {
    logic [RX_PORT_W-1:0]   port;
    logic                   sof;
    logic                   eof;
    logic [EOP_LEN_W-1:0]   eop_len;
    logic                   err;
    logic [PKT_LEN_W-1:0]   pkt_len;
    logic [CELL_DATA_W-1:0] data;
  } framed_cell_t;

  // Saturating 32-bit increment for event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/cell_reg_slice.sv
// One-deep valid/ready pipeline register for a framed cell (no skid buffer).
module cell_reg_slice
  import rv_p4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready_c,
  input  framed_cell_t i_cell,
  output logic         o_valid,
  input  logic         i_ready,
  output framed_cell_t o_cell
);

  logic         r_valid;
  framed_cell_t r_cell;

  assign o_ready_c = !r_valid || i_ready;
  assign o_valid   = r_valid;
  assign o_cell    = r_cell;

  // Load a new cell whenever the stage is empty or being drained; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cell  <= '0;
    end else if (o_ready_c) begin
      r_valid <= i_valid;
      if (i_valid) r_cell <= i_cell;
    end
  end

endmodule

// File: rtl/rx_cell_framer.sv
// Per-port cell framer: sof/eof sequencing, length accounting, max-size enforcement,
// orphan dropping. Optional counters are enabled by defining RX_FRAMER_STATS_EN.
module rx_cell_framer
  import rv_p4_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 32,
  parameter int unsigned MAX_PKT_BYTES = 9216,
  parameter int unsigned LEN_W         = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RX_PORT_W-1:0]   in_port,
  input  logic                   in_sof,
  input  logic                   in_eof,
  input  logic [EOP_LEN_W-1:0]   in_eop_len,
  input  logic [CELL_DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RX_PORT_W-1:0]   out_port,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [EOP_LEN_W-1:0]   out_eop_len,
  output logic [CELL_DATA_W-1:0] out_data,
  output logic                   out_err,
  output logic [LEN_W-1:0]       out_pkt_len,
  output logic                   abort_valid,
  output logic [RX_PORT_W-1:0]   abort_port
`ifdef RX_FRAMER_STATS_EN
  ,
  output logic [31:0]            stat_pkts,
  output logic [31:0]            stat_errs,
  output logic [31:0]            stat_orphans,
  output logic [31:0]            stat_aborts
`endif
);

  framer_state_e          r_state [NUM_PORTS];
  logic [LEN_W-1:0]       r_len   [NUM_PORTS];
  logic                   r_abort_valid;
  logic [RX_PORT_W-1:0]   r_abort_port;

  logic                   w_accept;
  logic                   w_in_ready;
  framer_state_e          w_cur_state;
  logic [LEN_W-1:0]       w_cur_len;
  logic                   w_eop_bad;
  logic [LEN_W-1:0]       w_b;
  logic [LEN_W-1:0]       w_new_len;
  logic                   w_over;
  logic                   w_fwd;
  logic                   w_abort;
  logic                   w_orphan;
  framer_state_e          w_nxt_state;
  logic [LEN_W-1:0]       w_nxt_len;
  logic                   w_out_eof;
  logic [EOP_LEN_W-1:0]   w_out_eop;
  logic                   w_out_err;
  logic [LEN_W-1:0]       w_out_len;
  framed_cell_t           w_cell;
  framed_cell_t           w_q;

  assign in_ready    = w_in_ready;
  assign w_accept    = in_valid && w_in_ready;
  assign w_cur_state = r_state[in_port];
  assign w_cur_len   = r_len[in_port];
  assign w_eop_bad   = in_eof && ((in_eop_len == '0) || (in_eop_len > EOP_LEN_W'(CELL_BYTES)));
  assign w_b         = (!in_eof || w_eop_bad) ? LEN_W'(CELL_BYTES) : LEN_W'(in_eop_len);
  assign w_new_len   = w_cur_len + w_b;
  assign w_over      = w_new_len > LEN_W'(MAX_PKT_BYTES);

  // Transition and forwarding decision for the cell on the input, based on its port's entry.
  always_comb begin
    w_fwd       = 1'b0;
    w_abort     = 1'b0;
    w_orphan    = 1'b0;
    w_nxt_state = w_cur_state;
    w_nxt_len   = w_cur_len;
    w_out_eof   = in_eof;
    w_out_eop   = in_eop_len;
    w_out_err   = 1'b0;
    w_out_len   = '0;
    if (in_sof) begin
      // A sof always starts fresh; only an open packet is reported as aborted.
      w_fwd   = 1'b1;
      w_abort = (w_cur_state == IN_PKT);
      if (in_eof) begin
        w_out_err   = w_eop_bad;
        w_out_len   = w_b;
        w_nxt_state = IDLE;
        w_nxt_len   = '0;
      end else begin
        w_nxt_state = IN_PKT;
        w_nxt_len   = LEN_W'(CELL_BYTES);
      end
    end else begin
      unique case (w_cur_state)
        IN_PKT: begin
          w_fwd = 1'b1;
          if (in_eof) begin
            w_out_err   = w_over || w_eop_bad;
            w_out_len   = w_new_len;
            w_nxt_state = IDLE;
            w_nxt_len   = '0;
          end else if (w_over) begin
            // Oversize: close the packet downstream as errored, swallow the rest.
            w_out_eof   = 1'b1;
            w_out_err   = 1'b1;
            w_out_eop   = EOP_LEN_W'(CELL_BYTES);
            w_out_len   = w_new_len;
            w_nxt_state = DISCARD;
            w_nxt_len   = '0;
          end else begin
            w_nxt_len = w_new_len;
          end
        end
        DISCARD: begin
          if (in_eof) begin
            w_nxt_state = IDLE;
            w_nxt_len   = '0;
          end
        end
        default: w_orphan = 1'b1;
      endcase
    end
  end

  // Per-port state table, written only for the accepted cell's port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        r_state[i] <= IDLE;
        r_len[i]   <= '0;
      end
    end else if (w_accept) begin
      r_state[in_port] <= w_nxt_state;
      r_len[in_port]   <= w_nxt_len;
    end
  end

  // One-cycle abort pulse following the accept of a sof that hit an open packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_abort_valid <= 1'b0;
      r_abort_port  <= '0;
    end else begin
      r_abort_valid <= w_accept && w_abort;
      if (w_accept && w_abort) r_abort_port <= in_port;
    end
  end

  assign abort_valid = r_abort_valid;
  assign abort_port  = r_abort_port;

  assign w_cell = '{port:    in_port,
                    sof:     in_sof,
                    eof:     w_out_eof,
                    eop_len: w_out_eop,
                    err:     w_out_err,
                    pkt_len: PKT_LEN_W'(w_out_len),
                    data:    in_data};

  cell_reg_slice u_out_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (in_valid && w_fwd),
    .o_ready_c (w_in_ready),
    .i_cell    (w_cell),
    .o_valid   (out_valid),
    .i_ready   (out_ready),
    .o_cell    (w_q)
  );

  assign out_port    = w_q.port;
  assign out_sof     = w_q.sof;
  assign out_eof     = w_q.eof;
  assign out_eop_len = w_q.eop_len;
  assign out_data    = w_q.data;
  assign out_err     = w_q.err;
  assign out_pkt_len = LEN_W'(w_q.pkt_len);

`ifdef RX_FRAMER_STATS_EN
  logic [31:0] r_stat_pkts, r_stat_errs, r_stat_orphans, r_stat_aborts;

  // Saturating event counters, updated at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_pkts    <= '0;
      r_stat_errs    <= '0;
      r_stat_orphans <= '0;
      r_stat_aborts  <= '0;
    end else if (w_accept) begin
      if (w_fwd && w_out_eof)              r_stat_pkts    <= sat_inc(r_stat_pkts);
      if (w_fwd && w_out_eof && w_out_err) r_stat_errs    <= sat_inc(r_stat_errs);
      if (w_orphan)                        r_stat_orphans <= sat_inc(r_stat_orphans);
      if (w_abort)                         r_stat_aborts  <= sat_inc(r_stat_aborts);
    end
  end

  assign stat_pkts    = r_stat_pkts;
  assign stat_errs    = r_stat_errs;
  assign stat_orphans = r_stat_orphans;
  assign stat_aborts  = r_stat_aborts;
`endif

endmodule

// File: tb/tb_rx_cell_framer.sv
// Scoreboard bench for rx_cell_framer (MAX_PKT_BYTES=256 so oversize paths are short).
module tb_rx_cell_framer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [4:0]   in_port;
  logic         in_sof, in_eof;
  logic [6:0]   in_eop_len;
  logic [511:0] in_data;
  logic         out_valid, out_ready;
  logic [4:0]   out_port;
  logic         out_sof, out_eof;
  logic [6:0]   out_eop_len;
  logic [511:0] out_data;
  logic         out_err;
  logic [13:0]  out_pkt_len;
  logic         abort_valid;
  logic [4:0]   abort_port;
`ifdef RX_FRAMER_STATS_EN
  logic [31:0]  stat_pkts, stat_errs, stat_orphans, stat_aborts;
`endif

  rx_cell_framer #(.NUM_PORTS(32), .MAX_PKT_BYTES(256), .LEN_W(14)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_port     (in_port),
    .in_sof      (in_sof),
    .in_eof      (in_eof),
    .in_eop_len  (in_eop_len),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_port    (out_port),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_eop_len (out_eop_len),
    .out_data    (out_data),
    .out_err     (out_err),
    .out_pkt_len (out_pkt_len),
    .abort_valid (abort_valid),
    .abort_port  (abort_port)
`ifdef RX_FRAMER_STATS_EN
    ,
    .stat_pkts    (stat_pkts),
    .stat_errs    (stat_errs),
    .stat_orphans (stat_orphans),
    .stat_aborts  (stat_aborts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   port;
    logic         sof;
    logic         eof;
    logic [6:0]   eop;
    logic         err;
    logic [13:0]  len;
    logic [511:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] abort_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [511:0] mk(input int k);
    logic [31:0] w;
    w = 32'(k);
    return {16{w}};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      $display("FAIL %s: got %0h want %0h", nm, a, e);
      n_err++;
    end
  endtask

  task automatic push(input logic [4:0] p, input logic s, input logic e, input logic [6:0] el,
                      input logic er, input logic [13:0] ln, input int k);
    exp_t x;
    x = '{port: p, sof: s, eof: e, eop: el, err: er, len: ln, data: mk(k)};
    exp_q.push_back(x);
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout: in_ready stuck at 0 for port %0d", in_port);
      n_vec++;
      n_err++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive(input logic [4:0] p, input logic s, input logic e, input logic [6:0] el,
                       input int k);
    in_port    = p;
    in_sof     = s;
    in_eof     = e;
    in_eop_len = el;
    in_data    = mk(k);
    in_valid   = 1'b1;
  endtask

  task automatic send(input logic [4:0] p, input logic s, input logic e, input logic [6:0] el,
                      input int k);
    drive(p, s, e, el, k);
    wait_accept();
  endtask

  // Send a cell and expect it forwarded unchanged with the given err/len sideband.
  task automatic fwd(input logic [4:0] p, input logic s, input logic e, input logic [6:0] el,
                     input logic er, input logic [13:0] ln, input int k);
    push(p, s, e, el, er, ln, k);
    send(p, s, e, el, k);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every output handshake.
  initial begin : mon_out
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_vec++;
        a = '{port: out_port, sof: out_sof, eof: out_eof, eop: out_eop_len, err: out_err,
              len: out_pkt_len, data: out_data};
        if (exp_q.size() == 0) begin
          $display("FAIL out_unexpected: port %0d sof %0b eof %0b len %0d", out_port, out_sof,
                   out_eof, out_pkt_len);
          n_err++;
        end else begin
          e = exp_q.pop_front();
          if (a !== e)begin
            $display("FAIL out_cell: got port %0d sof %0b eof %0b eop %0d err %0b len %0d data_ok %0b, want port %0d sof %0b eof %0b eop %0d err %0b len %0d",
                     a.port, a.sof, a.eof, a.eop, a.err, a.len, (a.data === e.data),
                     e.port, e.sof, e.eof, e.eop, e.err, e.len);
            n_err++;
          end
        end
      end
    end
  end

  // Abort monitor: every pulse must match a queued expectation.
  initial begin : mon_abort
    logic [4:0] ep;
    forever begin
      @(negedge clk);
      if (rst_n && abort_valid) begin
        n_vec++;
        if (abort_q.size() == 0) begin
          $display("FAIL abort_unexpected: port %0d", abort_port);
          n_err++;
        end else begin
          ep = abort_q.pop_front();
          if (abort_port !== ep) begin
            $display("FAIL abort_port: got %0d want %0d", abort_port, ep);
            n_err++;
          end
        end
      end
    end
  end

  initial begin : stim
    logic [511:0] held_data;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_port    = '0;
    in_sof     = 1'b0;
    in_eof     = 1'b0;
    in_eop_len = '0;
    in_data    = '0;
    out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_abort_valid", 32'(abort_valid), 0);
    chk("rst_out_pkt_len", 32'(out_pkt_len), 0);
    chk("rst_out_data_zero", 32'(out_data == '0), 1);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Single-cell packet.
    fwd(3, 1, 1, 60, 0, 60, 100);

    // Interleaved multi-cell packets, plus same-port back-to-back.
    fwd(7, 1, 0, 0, 0, 0, 200);
    fwd(9, 1, 0, 0, 0, 0, 300);
    fwd(7, 0, 0, 0, 0, 0, 201);
    fwd(9, 0, 1, 64, 0, 128, 301);
    fwd(7, 0, 1, 10, 0, 138, 202);
    fwd(5, 1, 0, 0, 0, 0, 400);
    fwd(5, 0, 0, 0, 0, 0, 401);
    fwd(5, 0, 1, 1, 0, 129, 402);

    // Orphan on an idle port: dropped, accepted.
    send(1, 0, 0, 0, 500);
    chk("orphan_in_ready", 32'(in_ready), 1);
`ifdef RX_FRAMER_STATS_EN
    chk("stat_orphans", stat_orphans, 1);
`endif

    // Abort of an open packet by a new sof.
    fwd(2, 1, 0, 0, 0, 0, 600);
    abort_q.push_back(5'd2);
    fwd(2, 1, 0, 0, 0, 0, 601);
    fwd(2, 0, 1, 20, 0, 84, 602);
    idle(2);
`ifdef RX_FRAMER_STATS_EN
    chk("stat_aborts", stat_aborts, 1);
`endif

    // Oversize: 5th cell closes as errored, rest dropped until eof.
    fwd(4, 1, 0, 0, 0, 0, 700);
    fwd(4, 0, 0, 0, 0, 0, 701);
    fwd(4, 0, 0, 0, 0, 0, 702);
    fwd(4, 0, 0, 0, 0, 0, 703);
    push(4, 0, 1, 64, 1, 320, 704);
    send(4, 0, 0, 0, 704);
    send(4, 0, 0, 0, 705);
    send(4, 0, 1, 10, 706);
    fwd(4, 1, 1, 33, 0, 33, 707);

    // Length boundary: exactly MAX is fine, MAX+1 at eof is an error.
    fwd(8, 1, 0, 0, 0, 0, 800);
    fwd(8, 0, 0, 0, 0, 0, 801);
    fwd(8, 0, 0, 0, 0, 0, 802);
    fwd(8, 0, 1, 64, 0, 256, 803);
    fwd(8, 1, 0, 0, 0, 0, 810);
    fwd(8, 0, 0, 0, 0, 0, 811);
    fwd(8, 0, 0, 0, 0, 0, 812);
    fwd(8, 0, 0, 0, 0, 0, 813);
    fwd(8, 0, 1, 1, 1, 257, 814);

    // Illegal eop_len values count as 64 bytes and flag err.
    fwd(6, 1, 1, 0, 1, 64, 900);
    fwd(6, 1, 0, 0, 0, 0, 901);
    fwd(6, 0, 1, 70, 1, 128, 902);

    // sof while discarding restarts cleanly with no abort.
    fwd(13, 1, 0, 0, 0, 0, 1000);
    fwd(13, 0, 0, 0, 0, 0, 1001);
    fwd(13, 0, 0, 0, 0, 0, 1002);
    fwd(13, 0, 0, 0, 0, 0, 1003);
    push(13, 0, 1, 64, 1, 320, 1004);
    send(13, 0, 0, 0, 1004);
    fwd(13, 1, 1, 2, 0, 2, 1005);
    idle(3);

    // Backpressure: output held, input stalled, nothing lost or duplicated.
    out_ready = 1'b0;
    fwd(11, 1, 1, 5, 0, 5, 1100);
    held_data = out_data;
    push(12, 1, 1, 6, 0, 6, 1200);
    drive(12, 1, 1, 6, 1200);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_port", 32'(out_port), 11);
      chk("stall_out_data", 32'(out_data == held_data), 1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    idle(3);

    // Reset mid-packet clears the open state.
    fwd(10, 1, 0, 0, 0, 0, 1300);
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(10, 0, 1, 9, 1301);
    fwd(10, 1, 1, 9, 0, 9, 1302);

    idle(10);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    chk("aborts_drained", 32'(abort_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
